// File: rtl/kypd_pkg.sv
// Shared constants for the keypad entry buffer.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package kypd_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Packed table: element i is the pattern for hex digit i.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/kypd_entry_buffer_hex7seg.sv
// Hex nibble to active-low seven-segment decoder.
// Purely combinational lookup into the shared table.
module hex7seg
  import kypd_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/kypd_entry_buffer.sv
// Keypad entry buffer: 4-digit shift buffer
// with a multiplexed seven-segment display scan.
module kypd_entry_buffer
  import kypd_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        clr,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic [15:0] digits,
  output logic [2:0]  count
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  localparam logic [2:0] FULL = 3'(NUM_DIGITS);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [15:0]   digits_q, digits_d;
  logic [2:0]    count_q, count_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          tick;
  logic          lit;
  logic [3:0]    nib;
  logic [6:0]    seg_hex;

  assign tick = (cnt_q == LAST);

  // Slot being loaded on this tick and its digit.
  assign sel_d = tick ? sel_q + 2'd1 : sel_q;
  assign nib   = digits_q[{sel_d, 2'b00} +: 4];
  assign lit   = ({1'b0, sel_d} < count_q);

  hex7seg u_hex (
    .hex_i (nib),
    .seg_o (seg_hex)
  );

  // Refresh divider wraps at REFRESH_DIV-1.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (tick) cnt_d = '0;
  end

  // Shift buffer; clear beats a same-cycle key.
  always_comb begin
    digits_d = digits_q;
    count_d  = count_q;
    if (clr) begin
      digits_d = '0;
      count_d  = '0;
    end else if (key_valid) begin
      digits_d = {digits_q[11:0], key_code};
      if (count_q != FULL) count_d = count_q + 3'd1;
    end
  end

  // Display outputs only move on a tick.
  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    if (tick) begin
      if (lit) begin
        an_d  = ~(4'b0001 << sel_d);
        seg_d = seg_hex;
      end else begin
        an_d  = 4'hF;
        seg_d = SEG_BLANK;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      sel_q    <= '0;
      digits_q <= '0;
      count_q  <= '0;
      an_q     <= 4'hF;
      seg_q    <= SEG_BLANK;
    end else begin
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      digits_q <= digits_d;
      count_q  <= count_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign an     = an_q;
  assign seg    = seg_q;
  assign digits = digits_q;
  assign count  = count_q;

endmodule

// File: tb/tb_kypd_entry_buffer.sv
// Bench for kypd_entry_buffer: vector table,
// directed scan sequences and random traffic.
module tb_kypd_entry_buffer;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        clr = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] digits;
  logic [2:0]  count;

  kypd_entry_buffer #(.REFRESH_DIV(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .clr       (clr),
    .an        (an),
    .seg       (seg),
    .digits    (digits),
    .count     (count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [6:0] hex_tb [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic [3:0] q[$];
  int         cyc = 0;
  logic [3:0] m_an = 4'hF;
  logic [6:0] m_seg = 7'h7F;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] m_digits();
    logic [15:0] d = '0;
    foreach (q[i]) d = {d[11:0], q[i]};
    return d;
  endfunction

  task automatic step(input logic r, input logic kv,
                      input logic [3:0] kc, input logic c);
    int s;
    rst = r; key_valid = kv; key_code = kc; clr = c;
    @(posedge clk);
    if (r) begin
      q.delete();
      cyc = 0;
      m_an = 4'hF;
      m_seg = 7'h7F;
    end else begin
      cyc++;
      if (cyc % D == 0) begin
        s = (cyc / D) % 4;
        if (s < q.size()) begin
          m_an = ~(4'b0001 << s);
          m_seg = hex_tb[q[q.size() - 1 - s]];
        end else begin
          m_an = 4'hF;
          m_seg = 7'h7F;
        end
      end
      if (c) q.delete();
      else if (kv) begin
        q.push_back(kc);
        if (q.size() > 4) void'(q.pop_front());
      end
    end
    #1;
    chk("model", {1'b0, digits, count, an, seg},
        {1'b0, m_digits(), 3'(q.size()), m_an, m_seg});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic key(input logic [3:0] k);
    step(1'b0, 1'b1, k, 1'b0);
  endtask

  task automatic wait_an(input logic [3:0] tgt);
    bit hit = 0;
    for (int i = 0; i < 8 * D + 4; i++) begin
      idle();
      if (an == tgt) begin
        hit = 1;
        break;
      end
    end
    chk("wait_an", {31'b0, hit}, 32'd1);
  endtask

  typedef struct {
    logic        r;
    logic        kv;
    logic [3:0]  kc;
    logic        c;
    logic [15:0] ed;
    logic [2:0]  ec;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic r, logic kv, logic [3:0] kc,
                              logic c, logic [15:0] ed, logic [2:0] ec);
    vec_t v;
    v.r = r; v.kv = kv; v.kc = kc; v.c = c; v.ed = ed; v.ec = ec;
    return v;
  endfunction

  initial begin
    logic [3:0] pan;
    logic [6:0] pseg;

    tv.push_back(mk(1, 0, 4'h0, 0, 16'h0000, 3'd0));
    tv.push_back(mk(1, 0, 4'h0, 0, 16'h0000, 3'd0));
    tv.push_back(mk(1, 1, 4'h7, 0, 16'h0000, 3'd0));
    tv.push_back(mk(0, 1, 4'h1, 0, 16'h0001, 3'd1));
    tv.push_back(mk(0, 1, 4'h2, 0, 16'h0012, 3'd2));
    tv.push_back(mk(0, 1, 4'h3, 0, 16'h0123, 3'd3));
    tv.push_back(mk(0, 0, 4'h0, 1, 16'h0000, 3'd0));
    tv.push_back(mk(0, 1, 4'h1, 0, 16'h0001, 3'd1));
    tv.push_back(mk(0, 1, 4'h2, 0, 16'h0012, 3'd2));
    tv.push_back(mk(0, 1, 4'h3, 0, 16'h0123, 3'd3));
    tv.push_back(mk(0, 1, 4'h4, 0, 16'h1234, 3'd4));
    tv.push_back(mk(0, 1, 4'h5, 0, 16'h2345, 3'd4));
    tv.push_back(mk(0, 1, 4'hF, 0, 16'h345F, 3'd4));
    tv.push_back(mk(0, 0, 4'h0, 1, 16'h0000, 3'd0));
    tv.push_back(mk(0, 1, 4'h6, 0, 16'h0006, 3'd1));
    tv.push_back(mk(0, 1, 4'h7, 0, 16'h0067, 3'd2));
    tv.push_back(mk(0, 1, 4'h9, 1, 16'h0000, 3'd0));
    tv.push_back(mk(0, 0, 4'h0, 0, 16'h0000, 3'd0));

    foreach (tv[i]) begin
      step(tv[i].r, tv[i].kv, tv[i].kc, tv[i].c);
      chk($sformatf("vec%0d", i), {13'b0, digits, count},
          {13'b0, tv[i].ed, tv[i].ec});
    end

    // Reset state, then blank display across 8 ticks.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h0, 1'b0);
    chk("rst_an", {28'b0, an}, 32'hF);
    chk("rst_seg", {25'b0, seg}, 32'h7F);
    chk("rst_dig", {16'b0, digits}, 32'h0);
    chk("rst_cnt", {29'b0, count}, 32'h0);
    for (int i = 0; i < 8 * D; i++) begin
      idle();
      chk("idle_an", {28'b0, an}, 32'hF);
    end

    // Three digits: slots 0..2 lit, slot 3 blank.
    key(4'h1); key(4'h2); key(4'h3);
    chk("k123", {13'b0, digits, count}, {13'b0, 16'h0123, 3'd3});
    wait_an(4'b1110);
    chk("s0_seg", {25'b0, seg}, 32'h30);
    wait_an(4'b1101);
    chk("s1_seg", {25'b0, seg}, 32'h24);
    wait_an(4'b1011);
    chk("s2_seg", {25'b0, seg}, 32'h79);
    for (int i = 0; i < D; i++) idle();
    chk("s3_blank", {21'b0, an, seg}, {21'b0, 4'hF, 7'h7F});

    // Full buffer: oldest slot shows digit 2.
    step(1'b0, 1'b0, 4'h0, 1'b1);
    for (int k = 1; k <= 5; k++) key(4'(k));
    chk("k12345", {13'b0, digits, count}, {13'b0, 16'h2345, 3'd4});
    wait_an(4'b0111);
    chk("s3_seg", {25'b0, seg}, 32'h24);

    // Mid-slot entry must not disturb the display.
    step(1'b0, 1'b0, 4'h0, 1'b1);
    for (int i = 0; i < D && (cyc % D) != 0; i++) idle();
    pan = an;
    pseg = seg;
    key(4'h8);
    chk("hold0", {21'b0, an, seg}, {21'b0, pan, pseg});
    while ((cyc % D) != D - 1) begin
      idle();
      chk("hold", {21'b0, an, seg}, {21'b0, pan, pseg});
    end
    wait_an(4'b1110);
    chk("k8_seg", {25'b0, seg}, 32'h00);

    // Reset during slot 2 restarts the scan.
    key(4'h1); key(4'h2);
    wait_an(4'b1011);
    idle();
    step(1'b1, 1'b1, 4'h5, 1'b0);
    chk("mrst", {18'b0, an, seg, count}, {18'b0, 4'hF, 7'h7F, 3'd0});
    key(4'h1); key(4'h2); idle();
    chk("pre_tick", {28'b0, an}, 32'hF);
    idle();
    chk("first_tick", {21'b0, an, seg}, {21'b0, 4'b1101, 7'h79});

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 100) == 0, ($urandom % 3) == 0,
           4'($urandom), ($urandom % 25) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
